// File: rtl/tpu_pkg.sv
// Shared TPU definitions: packer FSM states and the default operand
// geometry used by the packer, skew buffer and systolic array.
package tpu_pkg;
  localparam int unsigned BITS_AB = 8;
  localparam int unsigned DIM     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/b_row_packer.sv
// Packs a serial row-major B stream into DIM-wide rows for the skew buffer,
// then drives the zero-data drain enables and pulses done.
module b_row_packer #(
  parameter int unsigned BITS_AB = tpu_pkg::BITS_AB,
  parameter int unsigned DIM     = tpu_pkg::DIM
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [BITS_AB-1:0]              in_data,
  output logic [DIM-1:0][BITS_AB-1:0]     Bout,
  output logic                            en_out,
  output logic                            busy,
  output logic                            done
);
  import tpu_pkg::*;

  localparam int unsigned COL_W = $clog2(DIM);
  localparam int unsigned ROW_W = $clog2(DIM + 1);
  localparam int unsigned DRN_W = $clog2(2 * DIM);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(DIM - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DIM - 1);
  localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(DIM);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(2 * DIM - 1);

  state_t                        state_q, state_d;
  logic [COL_W-1:0]              col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0]              row_cnt_q, row_cnt_d;
  logic [DRN_W-1:0]              drain_cnt_q, drain_cnt_d;
  logic [DIM-1:0][BITS_AB-1:0]   asm_q, asm_d;
  logic [DIM-1:0][BITS_AB-1:0]   bout_q, bout_d;
  logic                          en_q, en_d;
  logic                          ready_q, ready_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    drain_cnt_d = drain_cnt_q;
    asm_d       = asm_q;
    bout_d      = bout_q;
    en_d        = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // done_q high means we are in the cycle right after a drain: ignore start
        if (start && !done_q) begin
          state_d     = FILL;
          col_cnt_d   = '0;
          row_cnt_d   = '0;
          drain_cnt_d = '0;
        end
      end
      FILL: begin
        if (in_valid && ready_q) begin
          asm_d[col_cnt_q] = in_data;
          col_cnt_d        = col_cnt_q + 1'b1;
          if (col_cnt_q == COL_LAST) begin
            bout_d = asm_d;
            en_d   = 1'b1;
            if (row_cnt_q != ROW_FULL) row_cnt_d = row_cnt_q + 1'b1;
            if (row_cnt_q == ROW_LAST) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRN_LAST) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
          en_d        = 1'b1;
          bout_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == FILL) && (row_cnt_d < ROW_FULL);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      drain_cnt_q <= '0;
      asm_q       <= '0;
      bout_q      <= '0;
      en_q        <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      asm_q       <= asm_d;
      bout_q      <= bout_d;
      en_q        <= en_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready = ready_q;
  assign Bout     = bout_q;
  assign en_out   = en_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_b_row_packer.sv
// Directed bench for b_row_packer (BITS_AB = 8, DIM = 8).
module tb_b_row_packer;
  localparam int unsigned BITS_AB = 8;
  localparam int unsigned DIM     = 8;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        start;
  logic                        in_valid;
  logic                        in_ready;
  logic [BITS_AB-1:0]          in_data;
  logic [DIM-1:0][BITS_AB-1:0] bout;
  logic                        en_out;
  logic                        busy;
  logic                        done;

  int errors   = 0;
  int checks   = 0;
  int en_cnt   = 0;
  int done_cnt = 0;

  b_row_packer #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .Bout     (bout),
    .en_out   (en_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (en_out) en_cnt++;
    if (done) done_cnt++;
  endtask

  function automatic logic [63:0] row_of(input int base);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) r[j*8 +: 8] = 8'(base + j);
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start busy", 64'(busy), 64'd1);
    chk("start ready", 64'(in_ready), 64'd1);
  endtask

  task automatic feed_row(input int base);
    for (int j = 0; j < 8; j++) begin
      in_valid = 1'b1;
      in_data  = 8'(base + j);
      step();
      if (j < 7) chk("mid-row en", 64'(en_out), 64'd0);
    end
    chk("row en", 64'(en_out), 64'd1);
    chk("row data", 64'(bout), row_of(base));
  endtask

  // in_valid stays high through the drain to show nothing is accepted
  task automatic drain(input int start_at);
    in_data = 8'h55;
    chk("drain ready low", 64'(in_ready), 64'd0);
    chk("drain busy", 64'(busy), 64'd1);
    for (int d = 0; d < 15; d++) begin
      start = (d == start_at);
      step();
      chk("drain en", 64'(en_out), 64'd1);
      chk("drain zero", 64'(bout), 64'd0);
      chk("drain no done", 64'(done), 64'd0);
    end
    start = 1'b0;
    in_valid = 1'b0;
    step();
    chk("done pulse", 64'(done), 64'd1);
    chk("done busy", 64'(busy), 64'd0);
    chk("done en", 64'(en_out), 64'd0);
  endtask

  initial begin
    logic [7:0]  neg_vals [8];
    logic [63:0] neg_row;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    #2;
    chk("reset bout", 64'(bout), 64'd0);
    chk("reset en", 64'(en_out), 64'd0);
    chk("reset ready", 64'(in_ready), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    step();
    rst = 1'b0;
    step();

    // Valid data in IDLE must not be taken
    in_valid = 1'b1; in_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle ready", 64'(in_ready), 64'd0);
      chk("idle busy", 64'(busy), 64'd0);
    end
    chk("idle no en", 64'(en_cnt), 64'd0);
    in_valid = 1'b0;

    // Full load 0..63, start held together with done
    en_cnt = 0; done_cnt = 0;
    do_start();
    for (int r = 0; r < 8; r++) feed_row(8 * r);
    drain(-1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start on done ignored", 64'(busy), 64'd0);
    chk("done single", 64'(done), 64'd0);
    chk("en total", 64'(en_cnt), 64'd23);
    chk("done count", 64'(done_cnt), 64'd1);

    // Gap after element 4, start during FILL and during DRAIN
    do_reset();
    en_cnt = 0; done_cnt = 0;
    do_start();
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1; in_data = 8'(j);
      step();
      chk("gap pre en", 64'(en_out), 64'd0);
    end
    in_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      step();
      chk("gap en", 64'(en_out), 64'd0);
      chk("gap ready", 64'(in_ready), 64'd1);
    end
    for (int j = 5; j < 8; j++) begin
      in_valid = 1'b1; in_data = 8'(j);
      step();
      if (j < 7) chk("gap post en", 64'(en_out), 64'd0);
    end
    chk("gap row en", 64'(en_out), 64'd1);
    chk("gap row data", 64'(bout), row_of(0));
    feed_row(8);
    in_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start in fill busy", 64'(busy), 64'd1);
    chk("start in fill ready", 64'(in_ready), 64'd1);
    for (int r = 2; r < 8; r++) feed_row(8 * r);
    drain(5);
    chk("gap en total", 64'(en_cnt), 64'd23);

    // Negative data passes bit-exact
    do_reset();
    do_start();
    neg_vals = '{8'h80, 8'hFF, 8'h7F, 8'h00, 8'h01, 8'hFE, 8'h40, 8'hC0};
    neg_row = 64'hC040_FE01_007F_FF80;
    for (int j = 0; j < 8; j++) begin
      in_valid = 1'b1; in_data = neg_vals[j];
      step();
    end
    in_valid = 1'b0;
    chk("neg en", 64'(en_out), 64'd1);
    chk("neg row", 64'(bout), neg_row);
    chk("neg col0 -128", 64'(bout[0]), 64'h80);
    chk("neg col1 -1", 64'(bout[1]), 64'hFF);
    chk("neg col2 127", 64'(bout[2]), 64'h7F);

    // Asynchronous reset after three rows plus a partial row
    do_reset();
    do_start();
    for (int r = 0; r < 3; r++) feed_row(100 + 8 * r);
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1; in_data = 8'(124 + j);
      step();
    end
    in_valid = 1'b0;
    chk("pre-rst busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst bout", 64'(bout), 64'd0);
    chk("rst en", 64'(en_out), 64'd0);
    chk("rst ready", 64'(in_ready), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    step();
    rst = 1'b0;
    step();
    en_cnt = 0; done_cnt = 0;
    do_start();
    for (int r = 0; r < 8; r++) feed_row(200 + 8 * r);
    drain(-1);
    chk("reload en total", 64'(en_cnt), 64'd23);
    chk("reload done count", 64'(done_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/b_row_packer.md
# b_row_packer

Upstream stage of the B-operand skew buffer (memB). It accepts a serial stream of signed B-matrix elements in row-major order and packs each group of DIM elements into one row vector. It drives exactly one full DIM×DIM load into the skew buffer: DIM row-load enables, then 2·DIM−1 zero-data drain enables so the deepest skew FIFO empties into the systolic array. It then signals completion.

## Interface
- BITS_AB, 8, element width (signed two's complement)
- DIM, 8, matrix dimension and row width; power of two ≥ 2

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a matrix load; honoured only in IDLE
- in_valid  in  1  in_data holds a valid element
- in_ready  out  1  packer accepts in_data this cycle (transfer = in_valid & in_ready)
- in_data  in  BITS_AB  signed element; row-major, element j of a row goes to column j
- Bout  out  [BITS_AB-1:0] × DIM  signed row vector; connects to skew buffer Bin
- en_out  out  1  shift/load enable; connects to skew buffer en
- busy  out  1  high in FILL and DRAIN
- done  out  1  one-cycle pulse when the drain completes

## Operation
- FSM states: IDLE, FILL, DRAIN. The packer is a registered Moore machine.
- IDLE to FILL: on start. start is ignored in FILL and DRAIN.
- In FILL, in_ready is high while row_cnt < DIM. No backpressure is applied mid-row.
- Each accepted element is written to assembly register asm[col_cnt]. col_cnt wraps from DIM−1 to 0.
- On the accept that fills column DIM−1:
  - the full row (asm with the new element at DIM−1) loads into the output register Bout;
  - en_out is set high for the next cycle only;
  - row_cnt increments.
- The assembly register and output register are separate, so streaming continues at one element per cycle while a row is being emitted.
- FILL to DRAIN: on the accept that completes row DIM−1. in_ready drops the following cycle.
- In DRAIN, after the final row pulse:
  - Bout is forced to all zeros;
  - en_out is held high for exactly 2·DIM−1 consecutive cycles, counted by drain_cnt.
- DRAIN to IDLE: after the last drain cycle. done pulses for one cycle on entry to IDLE.
- Over one load, en_out pulses exactly 3·DIM−1 times: DIM row pulses plus 2·DIM−1 drain pulses.
- Counter widths:
  - col_cnt is $clog2(DIM) bits.
  - row_cnt is $clog2(DIM+1) bits, saturating at DIM.
  - drain_cnt is $clog2(2·DIM) bits.
- No arithmetic is performed on data. Elements pass bit-exact.

## Timing
- Reset values: Bout = 0, en_out = 0, in_ready = 0, busy = 0, done = 0, state = IDLE, all counters = 0.
- start at cycle S: state = FILL and in_ready = 1 from S+1.
- Row latency: element DIM−1 of a row accepted at cycle T gives en_out = 1 with the row on Bout at T+1.
- Final element accepted at T:
  - T+1: last row pulse;
  - T+2 through T+2·DIM: drain pulses, Bout = 0;
  - T+2·DIM+1: done = 1, busy = 0, state = IDLE.
- in_valid low mid-row: col_cnt and asm hold; no en_out pulse until the row completes.
- in_valid high in IDLE or DRAIN: no transfer, because in_ready = 0.
- start coinciding with done: ignored. start must arrive at least one cycle after done.
- rst mid-FILL or mid-DRAIN: immediate return to reset values; any partial row is discarded.
- The skew buffer's load counter only clears on its own reset, so top level drives memB's rst_n from ~rst. Both blocks must be reset together before every load.

## Structure
- Shared package tpu_pkg holds:
  - the state typedef (enum IDLE, FILL, DRAIN);
  - default constants BITS_AB = 8 and DIM = 8, shared with the skew buffer and systolic array.
- Single module, no sub-modules. The assembly register, output register and counters are all local.

## Test plan
- Reset, start, then 64 consecutive elements with values 0..63 and in_valid held high. Required:
  - 8 row pulses, each row k = {8k..8k+7} with column j = 8k+j;
  - then exactly 15 drain pulses with Bout = 0;
  - done exactly once;
  - 23 en_out pulses in total.
- Same stream with in_valid deasserted for 3 cycles after element 4. Required: row 0 is emitted only after element 7 is accepted; row contents are unchanged.
- Negative data: elements −128, −1, 127 within a row. Required: they appear bit-exact in the corresponding Bout columns.
- rst asserted after 3 full rows. Required: all outputs return to 0 the same cycle; a new start and full load produce correct rows from row 0.
- start during FILL and during DRAIN, plus in_valid held high in IDLE. Required: no state change and no transfers.
- End-to-end with memB (DIM = 8). Required: the Bout of column c first carries row 0 data 8+c enables after the first row pulse.
